// File: rtl/conv_if_mc.sv
// Multi-channel converter interface: double-latched ADC capture to left-aligned signed words,
// and rounded/saturated DAC output with sticky clip flags, both paced by a shared sample strobe.
module conv_if_mc #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned CW      = 10,
    parameter int unsigned IW      = 16,
    parameter int unsigned ADC_FMT = 1,
    parameter int unsigned DAC_FMT = 0,
    parameter int unsigned DIV     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                loopback,
    input  logic                clr_clip,
    input  logic [NCH*CW-1:0]   adc,
    output logic [NCH*IW-1:0]   s_adc,
    output logic                adc_valid,
    input  logic [NCH*IW-1:0]   s_dac,
    output logic [NCH*CW-1:0]   dac,
    output logic [NCH-1:0]      clip
);

    localparam int unsigned       SH       = IW - CW;
    localparam int unsigned       CNTW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNTW-1:0]   CNT_LAST = CNTW'(DIV - 1);
    localparam logic signed [IW:0] RND     = (IW+1)'((64'd1 << SH) >> 1);
    localparam logic signed [IW:0] MAXV    = (IW+1)'((64'd1 << (CW-1)) - 64'd1);
    localparam logic signed [IW:0] MINV    = ~MAXV;
    localparam logic [CW-1:0]     DAC_ZERO = (DAC_FMT == 0) ? CW'(64'd1 << (CW-1)) : '0;

    logic [CNTW-1:0]   cnt;
    logic [NCH*CW-1:0] dl;
    logic              stb_c;
    logic [NCH*IW-1:0] adc_word_c;
    logic [NCH*CW-1:0] dac_code_c;
    logic [NCH-1:0]    sat_c;
    logic [IW-1:0]     src_c;

    // Pin code -> left-aligned signed internal word.
    function automatic logic [IW-1:0] adc_to_int(input logic [CW-1:0] raw);
        logic [CW-1:0] v;
        v = raw;
        if (ADC_FMT == 0) v[CW-1] = ~v[CW-1];
        return IW'(v) << SH;
    endfunction

    // Internal word -> {saturated, pin code}; one guard bit absorbs the rounding carry.
    function automatic logic [CW:0] int_to_dac(input logic [IW-1:0] x);
        logic signed [IW:0] r;
        logic [CW-1:0]      q;
        logic               sat;
        r   = ($signed({x[IW-1], x}) + RND) >>> SH;
        sat = 1'b1;
        if (r > MAXV)      q = MAXV[CW-1:0];
        else if (r < MINV) q = MINV[CW-1:0];
        else begin
            q   = r[CW-1:0];
            sat = 1'b0;
        end
        if (DAC_FMT == 0) q[CW-1] = ~q[CW-1];
        return {sat, q};
    endfunction

    assign stb_c = en & (cnt == CNT_LAST);

    // Per-channel conversions; loopback reads the currently registered ADC words.
    always_comb begin
        adc_word_c = '0;
        dac_code_c = '0;
        sat_c      = '0;
        src_c      = '0;
        for (int k = 0; k < NCH; k++) begin
            adc_word_c[k*IW +: IW] = adc_to_int(dl[k*CW +: CW]);
            src_c = loopback ? s_adc[k*IW +: IW] : s_dac[k*IW +: IW];
            {sat_c[k], dac_code_c[k*CW +: CW]} = int_to_dac(src_c);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            dl        <= '0;
            s_adc     <= '0;
            adc_valid <= 1'b0;
            dac       <= {NCH{DAC_ZERO}};
            clip      <= '0;
        end else begin
            dl        <= adc;
            adc_valid <= stb_c;
            if (!en || cnt == CNT_LAST) cnt <= '0;
            else                        cnt <= cnt + CNTW'(1);
            if (stb_c) begin
                s_adc <= adc_word_c;
                dac   <= dac_code_c;
            end
            // A saturation on this strobe outranks a simultaneous clear.
            clip <= (stb_c ? sat_c : '0) | (clr_clip ? '0 : clip);
        end
    end

endmodule

// File: doc/conv_if_mc.md
Name: conv_if_mc

Overview:
- Parametrised multi-channel ADC/DAC data-path interface between converter pins and the signed internal DSP core.
- ADC path: double-latches parallel ADC buses and converts them to left-aligned signed internal words.
- DAC path: rounds and saturates signed internal words, then converts them to the DAC pin format.
- Extends the fixed two-channel, 10-bit conversion stage with channel count, width and format generics, sample-rate strobing, saturation with sticky clip flags, and digital loopback.

Parameters:
- NCH, 2: number of channels; channel k occupies slice [k*W +: W] of each bus.
- CW, 10: converter bit width (ADC and DAC), ≥2.
- IW, 16: internal signed word width, IW ≥ CW.
- ADC_FMT, 1: 1 = ADC pins are two's complement; 0 = offset-binary.
- DAC_FMT, 0: 1 = DAC pins are two's complement; 0 = offset-binary.
- DIV, 1: sample strobe period in clk cycles, ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- en  in  1  strobe counter enable.
- loopback  in  1  1 = DAC path is fed from s_adc instead of s_dac.
- clr_clip  in  1  synchronous clear of clip flags.
- adc  in  NCH*CW  raw ADC pins.
- s_adc  out  NCH*IW  signed left-aligned ADC samples.
- adc_valid  out  1  one-cycle pulse when s_adc updates.
- s_dac  in  NCH*IW  signed DAC samples from the core.
- dac  out  NCH*CW  DAC pins.
- clip  out  NCH  sticky per-channel DAC saturation flag.

Behaviour:
- Reset (rst=0, async):
  - dl, s_adc, adc_valid, clip, counter all 0.
  - dac per channel = converter-format zero: 1<<(CW-1) if DAC_FMT=0, else 0.
- Strobe counter cnt (0..DIV-1):
  - en=1: increments, wraps DIV-1→0.
  - en=0: holds at 0; no strobes; all outputs hold.
  - stb (internal) = en & (cnt==DIV-1). With DIV=1, stb = en.
- ADC stage 1: dl <= adc every cycle, regardless of en.
- ADC stage 2 (on stb):
  - per channel v = dl slice; if ADC_FMT=0, invert MSB of v.
  - s_adc slice <= $signed(v) <<< (IW-CW).
- adc_valid <= stb, so it is high exactly in the cycle the new s_adc is visible. Latency: pins→s_adc = 2 cycles when stb is asserted in the cycle after capture.
- DAC source x = loopback ? s_adc slice : s_dac slice, sampled on stb. The loopback mux switches only at strobe boundaries.
- DAC conversion, per channel:
  - Evaluate in IW+1 bits: r = (x + (IW>CW ? 1<<(IW-CW-1) : 0)) >>> (IW-CW). This is round half-up and can exceed range.
  - Saturate r to [-(2^(CW-1)), 2^(CW-1)-1].
  - If DAC_FMT=0, invert MSB of the CW-bit result.
  - dac slice <= result, registered on stb. Latency s_dac→dac = 1 cycle after strobe.
- Clip flag:
  - clip[k] <= 1 on any stb where channel k saturated.
  - clr_clip=1 clears clip to 0, except that a saturation in the same cycle wins (flag stays/sets 1).
- Channels are fully independent; no cross-channel arithmetic.
- Reset asserted mid-strobe-period: counter restarts at 0; first strobe after release is DIV cycles later.

Test Plan:
- Reset values (NCH=2, CW=10, IW=16, ADC_FMT=0, DAC_FMT=0): assert rst=0 -> dac=0x200 both channels, s_adc=0, clip=0, adc_valid=0; release -> first adc_valid at cycle DIV.
- ADC conversion (ADC_FMT=0, DIV=1): adc ch0=0x000, ch1=0x3FF -> 2 cycles later s_adc ch0=0x8000, ch1=0x7FC0; adc=0x200 -> s_adc=0x0000.
- DAC rounding/saturation: s_dac=0x001F -> dac=0x200; 0x0020 -> 0x201; 0x7FFF -> 0x3FF with clip[0]=1; 0x8000 -> 0x000 with clip unchanged; clr_clip pulse -> clip=0; clr_clip coincident with 0x7FFF -> clip stays 1.
- Strobe/enable (DIV=4): adc_valid pulses every 4th cycle; dac and s_adc change only on those cycles; en=0 for 10 cycles -> no pulses, outputs hold; en=1 -> first pulse 4 cycles later.
- Loopback (ADC_FMT=1, DAC_FMT=0): loopback=1, adc=0x17F -> dac=0x37F one strobe after s_adc updates, s_dac ignored; loopback=0 -> dac follows s_dac from next strobe.
- Async reset mid-run (DIV=3, cnt=1): rst=0 for half a cycle -> outputs reset immediately without a clk edge; counter restarts at 0.
